// File: rtl/pipe_ex_arbiter.sv
// Round-robin front end that shares one pipe_ex datapath between two requesters.
// A tag pipeline matched to the datapath latency sends each result back to its issuer.
module pipe_ex_arbiter #(
  parameter int N   = 10,
  parameter int LAT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [N-1:0]               req0_A,
  input  logic [N-1:0]               req0_B,
  input  logic [N-1:0]               req0_C,
  input  logic [N-1:0]               req0_D,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [N-1:0]               req1_A,
  input  logic [N-1:0]               req1_B,
  input  logic [N-1:0]               req1_C,
  input  logic [N-1:0]               req1_D,
  output logic [N-1:0]               pipe_A,
  output logic [N-1:0]               pipe_B,
  output logic [N-1:0]               pipe_C,
  output logic [N-1:0]               pipe_D,
  input  logic [N-1:0]               pipe_F,
  output logic                       rsp0_valid,
  output logic                       rsp1_valid,
  output logic [N-1:0]               rsp_F,
  output logic [$clog2(LAT+1)-1:0]   in_flight
);

  localparam int CW = $clog2(LAT+1);

  logic           rr_ptr_q, rr_ptr_d;
  logic [LAT-1:0] vld_q, vld_d;
  logic [LAT-1:0] id_q, id_d;
  logic [CW-1:0]  in_flight_q, in_flight_d;
  logic           grant0, grant1, transfer, grant_id;

  // rr_ptr only breaks ties; a lone requester always wins
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        grant0 = !rr_ptr_q;
        grant1 = rr_ptr_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
    transfer = grant0 | grant1;
    grant_id = grant1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    pipe_A = req0_A;
    pipe_B = req0_B;
    pipe_C = req0_C;
    pipe_D = req0_D;
    if (grant1) begin
      pipe_A = req1_A;
      pipe_B = req1_B;
      pipe_C = req1_C;
      pipe_D = req1_D;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (transfer) rr_ptr_d = !grant_id;

    vld_d    = '0;
    id_d     = '0;
    vld_d[0] = transfer;
    id_d[0]  = grant_id;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end

    // Issue and retire on the same edge cancel out
    in_flight_d = in_flight_q;
    case ({transfer, vld_q[LAT-1]})
      2'b10:   in_flight_d = in_flight_q + CW'(1);
      2'b01:   in_flight_d = in_flight_q - CW'(1);
      default: in_flight_d = in_flight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= 1'b0;
      vld_q       <= '0;
      id_q        <= '0;
      in_flight_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      vld_q       <= vld_d;
      id_q        <= id_d;
      in_flight_q <= in_flight_d;
    end
  end

  assign rsp0_valid = vld_q[LAT-1] && !id_q[LAT-1];
  assign rsp1_valid = vld_q[LAT-1] &&  id_q[LAT-1];
  assign rsp_F      = pipe_F;
  assign in_flight  = in_flight_q;

endmodule

// File: tb/tb_pipe_ex_arbiter.sv
// Directed bench for pipe_ex_arbiter with a behavioural stand-in for pipe_ex.
// Results are compared against hand-computed constants.
module tb_pipe_ex_arbiter;

  localparam int N   = 10;
  localparam int LAT = 3;

  logic         clk;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [N-1:0] req0_A, req0_B, req0_C, req0_D;
  logic [N-1:0] req1_A, req1_B, req1_C, req1_D;
  logic [N-1:0] pipe_A, pipe_B, pipe_C, pipe_D, pipe_F;
  logic         rsp0_valid, rsp1_valid;
  logic [N-1:0] rsp_F;
  logic [1:0]   in_flight;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] s_ops [4][4] = '{'{10,12,6,3}, '{10,10,5,3}, '{20,11,1,4}, '{15,10,8,2}};
  int           s_exp [4]    = '{75, 66, 112, 62};
  logic [N-1:0] f0_ops [4][4] = '{'{1,2,3,1}, '{2,2,2,2}, '{5,5,5,5}, '{0,0,9,3}};
  logic [N-1:0] f1_ops [4][4] = '{'{1,1,1,1}, '{4,0,4,2}, '{100,100,0,1}, '{9,1,10,5}};
  int           f_exp  [8]    = '{5, 2, 8, 12, 50, 199, 18, 75};

  pipe_ex_arbiter #(.N(N), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_A(req0_A), .req0_B(req0_B), .req0_C(req0_C), .req0_D(req0_D),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_A(req1_A), .req1_B(req1_B), .req1_C(req1_C), .req1_D(req1_D),
    .pipe_A(pipe_A), .pipe_B(pipe_B), .pipe_C(pipe_C), .pipe_D(pipe_D),
    .pipe_F(pipe_F),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_F(rsp_F), .in_flight(in_flight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pipe_ex stand-in: operands captured at edge k give F after edge k+2
  logic [N-1:0] s1_q, d1_q, p2_q;
  always @(posedge clk) begin
    s1_q   <= (pipe_A + pipe_B) + (pipe_C - pipe_D);
    d1_q   <= pipe_D;
    p2_q   <= s1_q * d1_q;
    pipe_F <= p2_q;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(
    input logic v0, input logic [N-1:0] a0, b0, c0, d0,
    input logic v1, input logic [N-1:0] a1, b1, c1, d1);
    req0_valid = v0; req0_A = a0; req0_B = b0; req0_C = c0; req0_D = d0;
    req1_valid = v1; req1_A = a1; req1_B = b1; req1_C = c1; req1_D = d1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic v0, input logic v1, input int f);
    check_output({tag, ".rsp0_valid"}, 32'(rsp0_valid), 32'(v0));
    check_output({tag, ".rsp1_valid"}, 32'(rsp1_valid), 32'(v1));
    if (v0 || v1) check_output({tag, ".rsp_F"}, 32'(rsp_F), 32'(f));
  endtask

  initial begin
    int p0, p1, g;
    rst = 1'b1;
    apply_stimulus(1, 10, 12, 6, 3, 0, 0, 0, 0, 0);
    #1;
    check_output("rst_no_grant", 32'(req0_ready), 32'd0);
    step();
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    check_output("reset_in_flight", 32'(in_flight), 32'd0);
    check_rsp("reset", 0, 0, 0);

    $display("[TB] single issue");
    apply_stimulus(1, 10, 12, 6, 3, 0, 0, 0, 0, 0);
    #1;
    check_output("t1_ready0", 32'(req0_ready), 32'd1);
    check_output("t1_ready1", 32'(req1_ready), 32'd0);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_output("t1_in_flight_k", 32'(in_flight), 32'd1);
    step();
    check_rsp("t1_k1", 0, 0, 0);
    step();
    check_rsp("t1_k2", 1, 0, 75);
    check_output("t1_in_flight_k2", 32'(in_flight), 32'd1);
    step();
    check_rsp("t1_k3", 0, 0, 0);
    check_output("t1_in_flight_k3", 32'(in_flight), 32'd0);

    $display("[TB] contention");
    rst = 1'b1;
    step();
    rst = 1'b0;
    apply_stimulus(1, 10, 12, 6, 3, 1, 20, 11, 1, 4);
    #1;
    check_output("t2_ready0", 32'(req0_ready), 32'd1);
    check_output("t2_ready1", 32'(req1_ready), 32'd0);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 1, 20, 11, 1, 4);
    #1;
    check_output("t2_ready1_next", 32'(req1_ready), 32'd1);
    check_output("t2_ready0_next", 32'(req0_ready), 32'd0);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_output("t2_in_flight", 32'(in_flight), 32'd2);
    step();
    check_rsp("t2_r0", 1, 0, 75);
    step();
    check_rsp("t2_r1", 0, 1, 112);
    step();
    check_rsp("t2_idle", 0, 0, 0);
    check_output("t2_in_flight_end", 32'(in_flight), 32'd0);

    $display("[TB] streaming");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, 0, 0, 0, 0, 1, s_ops[i][0], s_ops[i][1], s_ops[i][2], s_ops[i][3]);
      #1;
      check_output($sformatf("t3_ready1_%0d", i), 32'(req1_ready), 32'd1);
      step();
      if (i >= 2) check_rsp($sformatf("t3_rsp_%0d", i-2), 0, 1, s_exp[i-2]);
      if (i == 2) check_output("t3_in_flight_max", 32'(in_flight), 32'd3);
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check_rsp("t3_rsp_2", 0, 1, s_exp[2]);
    step();
    check_rsp("t3_rsp_3", 0, 1, s_exp[3]);
    step();
    check_rsp("t3_idle", 0, 0, 0);
    check_output("t3_in_flight_end", 32'(in_flight), 32'd0);

    $display("[TB] fairness");
    p0 = 0;
    p1 = 0;
    for (int c = 0; c < 8; c++) begin
      int i0, i1;
      i0 = (p0 > 3) ? 3 : p0;
      i1 = (p1 > 3) ? 3 : p1;
      apply_stimulus(1, f0_ops[i0][0], f0_ops[i0][1], f0_ops[i0][2], f0_ops[i0][3],
                     1, f1_ops[i1][0], f1_ops[i1][1], f1_ops[i1][2], f1_ops[i1][3]);
      #1;
      g = c % 2;
      check_output($sformatf("t4_ready0_%0d", c), 32'(req0_ready), 32'(g == 0));
      check_output($sformatf("t4_ready1_%0d", c), 32'(req1_ready), 32'(g == 1));
      step();
      if (g == 0) p0++; else p1++;
      if (c >= 2) check_rsp($sformatf("t4_rsp_%0d", c-2), ((c-2) % 2) == 0, ((c-2) % 2) == 1, f_exp[c-2]);
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check_rsp("t4_rsp_6", 1, 0, f_exp[6]);
    step();
    check_rsp("t4_rsp_7", 0, 1, f_exp[7]);
    step();
    check_rsp("t4_idle", 0, 0, 0);

    $display("[TB] zero and mixed values");
    apply_stimulus(1, 8, 15, 5, 0, 0, 0, 0, 0, 0);
    #1;
    check_output("t5_ready0", 32'(req0_ready), 32'd1);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 1, 10, 20, 30, 1);
    #1;
    check_output("t5_ready1", 32'(req1_ready), 32'd1);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check_rsp("t5_zero", 1, 0, 0);
    step();
    check_rsp("t5_mixed", 0, 1, 59);
    step();
    check_rsp("t5_idle", 0, 0, 0);

    $display("[TB] reset mid-flight");
    apply_stimulus(1, 10, 12, 6, 3, 0, 0, 0, 0, 0);
    step();
    apply_stimulus(1, 20, 11, 1, 4, 0, 0, 0, 0, 0);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_output("t6_in_flight", 32'(in_flight), 32'd0);
    check_rsp("t6_after_rst0", 0, 0, 0);
    step();
    check_rsp("t6_after_rst1", 0, 0, 0);
    step();
    check_rsp("t6_after_rst2", 0, 0, 0);
    step();
    check_rsp("t6_after_rst3", 0, 0, 0);
    apply_stimulus(1, 10, 10, 5, 3, 1, 15, 10, 8, 2);
    #1;
    check_output("t6_rr_ptr_ready0", 32'(req0_ready), 32'd1);
    check_output("t6_rr_ptr_ready1", 32'(req1_ready), 32'd0);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_output("t6_in_flight_new", 32'(in_flight), 32'd1);
    step();
    step();
    check_rsp("t6_new_rsp", 1, 0, 66);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
